// File: rtl/fma_vec_checker_if.sv
// fma_vec_checker_if: operand/result bus between the vector checker (master) and the FMA under test (slave).
interface fma_vec_checker_if #(
    parameter int WIDTH  = 16,
    parameter int NFLAGS = 4
);
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [WIDTH-1:0]  z;
    logic [1:0]        roundmode;
    logic              mul;
    logic              add;
    logic              negp;
    logic              negz;
    logic              op_valid;
    logic              res_valid;
    logic [WIDTH-1:0]  result;
    logic [NFLAGS-1:0] flags;

    modport master (
        output x, y, z, roundmode, mul, add, negp, negz, op_valid,
        input  res_valid, result, flags
    );
    modport slave (
        input  x, y, z, roundmode, mul, add, negp, negz, op_valid,
        output res_valid, result, flags
    );
endinterface

// File: rtl/fma_vec_checker.sv
// fma_vec_checker: vector memory sequencer plus scoreboard checker for fma16/fma32 datapaths.
// Define FMA_CHK_FLAGS_EN to compare and store expected flags alongside the result.
module fma_vec_checker #(
    parameter int  WIDTH   = 16,
    parameter int  NFLAGS  = 4,
    parameter int  DEPTH   = 1024,
    parameter int  SBDEPTH = 8,
    parameter int  TIMEOUT = 256,
    localparam int AW      = $clog2(DEPTH),
    localparam int VW      = 4*WIDTH + 8 + NFLAGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [VW-1:0]     wr_data_i,
    input  logic              start_i,
    input  logic [AW:0]       count_i,
    fma_vec_checker_if.master fma,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       errors_o,
    output logic [AW:0]       completed_o,
    output logic [AW-1:0]     first_err_o,
    output logic              overrun_o,
    output logic              timeout_o
);
    localparam int SW = $clog2(SBDEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int RX = 3*WIDTH + 8 + NFLAGS;
    localparam int RY = 2*WIDTH + 8 + NFLAGS;
    localparam int RZ = WIDTH + 8 + NFLAGS;
    localparam int RC = WIDTH + NFLAGS;
    localparam int RR = NFLAGS;
    localparam logic [SW:0]   SB_FULL = (SW+1)'(SBDEPTH);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [VW-1:0]     mem [DEPTH];
    logic [VW-1:0]     vec_q;
    logic [AW-1:0]     idx_q;
    logic              op_valid_q;
    logic [AW:0]       ptr_q, cnt_q;
    logic [WIDTH-1:0]  sb_res [SBDEPTH];
    logic [AW-1:0]     sb_idx [SBDEPTH];
    logic [SW-1:0]     sb_wr_q, sb_rd_q;
    logic [SW:0]       sb_cnt_q, occ;
    logic [WW-1:0]     wd_q, wd_d;
    logic [31:0]       errors_q, errors_d;
    logic [AW:0]       completed_q, completed_d;
    logic [AW-1:0]     first_err_q, first_err_d;
    logic              overrun_q, overrun_d, timeout_q, timeout_d, done_q;
    logic              active, accept, push, pop, sb_empty, overrun_ev, mismatch;
    logic              issue, wd_count, wd_hit, sb_clr, unused_bits;
    logic [WIDTH-1:0]  head_res;
    logic [AW-1:0]     head_idx;

    assign active     = (state_q == RUN) || (state_q == DRAIN);
    assign accept     = start_i && !active;
    assign push       = op_valid_q;
    assign sb_empty   = (sb_cnt_q == '0);
    // An empty scoreboard forwards the entry being pushed so zero-latency results check in the same cycle.
    assign pop        = fma.res_valid && (!sb_empty || push);
    assign overrun_ev = fma.res_valid && sb_empty && !push;
    assign head_res   = sb_empty ? vec_q[RR +: WIDTH] : sb_res[sb_rd_q];
    assign head_idx   = sb_empty ? idx_q : sb_idx[sb_rd_q];
    assign occ        = sb_cnt_q + (SW+1)'(push) - (SW+1)'(pop);
`ifdef FMA_CHK_FLAGS_EN
    logic [NFLAGS-1:0] sb_flg [SBDEPTH];
    logic [NFLAGS-1:0] head_flg;
    assign head_flg    = sb_empty ? vec_q[NFLAGS-1:0] : sb_flg[sb_rd_q];
    assign mismatch    = pop && ((fma.result != head_res) || (fma.flags != head_flg));
    assign unused_bits = ^vec_q[RC+6 +: 2];
`else
    assign mismatch    = pop && (fma.result != head_res);
    assign unused_bits = ^{vec_q[RC+6 +: 2], vec_q[NFLAGS-1:0], fma.flags};
`endif

    assign wd_count = active && !sb_empty && !fma.res_valid;
    assign wd_hit   = wd_count && (wd_q == WD_MAX);
    assign wd_d     = (wd_count && !wd_hit) ? wd_q + WW'(1) : '0;
    assign sb_clr   = accept || wd_hit;
    // Issue reserves a slot a cycle early because the registered read pushes one cycle later.
    assign issue    = (state_q == RUN) && (ptr_q != cnt_q) && (occ < SB_FULL) && !wd_hit;

    assign errors_d    = accept ? '0 : ((mismatch || overrun_ev) && errors_q != '1) ? errors_q + 32'd1 : errors_q;
    assign completed_d = accept ? '0 : completed_q + (AW+1)'(pop);
    assign first_err_d = accept ? '0 : (mismatch && errors_q == '0) ? head_idx : first_err_q;
    assign overrun_d   = !accept && (overrun_q || overrun_ev);
    assign timeout_d   = !accept && (timeout_q || wd_hit);

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = (count_i == '0) ? DONE : RUN;
        else if (wd_hit)
            state_d = DONE;
        else if (state_q == RUN && ptr_q == cnt_q)
            state_d = DRAIN;
        else if (state_q == DRAIN && occ == '0)
            state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !active)
            mem[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_res[sb_wr_q] <= vec_q[RR +: WIDTH];
            sb_idx[sb_wr_q] <= idx_q;
`ifdef FMA_CHK_FLAGS_EN
            sb_flg[sb_wr_q] <= vec_q[NFLAGS-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            op_valid_q  <= 1'b0;
            vec_q       <= '0;
            idx_q       <= '0;
            sb_wr_q     <= '0;
            sb_rd_q     <= '0;
            sb_cnt_q    <= '0;
            wd_q        <= '0;
            errors_q    <= '0;
            completed_q <= '0;
            first_err_q <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= accept ? '0 : ptr_q + (AW+1)'(issue);
            cnt_q       <= accept ? count_i : cnt_q;
            op_valid_q  <= issue;
            vec_q       <= issue ? mem[ptr_q[AW-1:0]] : vec_q;
            idx_q       <= issue ? ptr_q[AW-1:0] : idx_q;
            sb_wr_q     <= sb_clr ? '0 : sb_wr_q + SW'(push);
            sb_rd_q     <= sb_clr ? '0 : sb_rd_q + SW'(pop);
            sb_cnt_q    <= sb_clr ? '0 : occ;
            wd_q        <= wd_d;
            errors_q    <= errors_d;
            completed_q <= completed_d;
            first_err_q <= first_err_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            done_q      <= (state_q == DONE) && !start_i;
        end
    end

    assign fma.x         = vec_q[RX +: WIDTH];
    assign fma.y         = vec_q[RY +: WIDTH];
    assign fma.z         = vec_q[RZ +: WIDTH];
    assign fma.roundmode = vec_q[RC+4 +: 2];
    assign fma.mul       = vec_q[RC+3];
    assign fma.add       = vec_q[RC+2];
    assign fma.negp      = vec_q[RC+1];
    assign fma.negz      = vec_q[RC];
    assign fma.op_valid  = op_valid_q;
    assign busy_o        = active;
    assign done_o        = done_q;
    assign errors_o      = errors_q;
    assign completed_o   = completed_q;
    assign first_err_o   = first_err_q;
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_fma_vec_checker.sv
// tb_fma_vec_checker: directed vectors against a behavioural FMA responder of latency 0 or 3.
module tb_fma_vec_checker;
    localparam int W = 16, NF = 4, D = 16, SB = 2, TO = 16, AW = 4, VW = 4*W + 8 + NF;

    logic          clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [VW-1:0] wr_data = '0;
    logic [AW:0]   count = '0;
    logic          busy, done, overrun, timeout;
    logic [31:0]   errors;
    logic [AW:0]   completed;
    logic [AW-1:0] first_err;
    logic          slow = 1'b0, mute = 1'b0, inj = 1'b0, bad_res = 1'b0, bad_flg = 1'b0;
    int            n_checks = 0, n_fail = 0, op_k = 0, max_out, ops_seen, c0, c1, c2;
    logic [53:0]   op1;

    logic [15:0] vx [4] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h7BFF};
    logic [15:0] vy [4] = '{16'h3C00, 16'h4200, 16'h0000, 16'h7BFF};
    logic [15:0] vz [4] = '{16'h0000, 16'h3C00, 16'h3C00, 16'h0000};
    logic [7:0]  vc [4] = '{8'h08, 8'h3D, 8'h04, 8'h08};
    logic [15:0] vr [4] = '{16'h3C00, 16'h4500, 16'h3C00, 16'h7C00};
    logic [3:0]  vf [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101};

    always #5 clk = ~clk;

    fma_vec_checker_if #(.WIDTH(W), .NFLAGS(NF)) ifc();

    fma_vec_checker #(.WIDTH(W), .NFLAGS(NF), .DEPTH(D), .SBDEPTH(SB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .count_i(count), .fma(ifc), .busy_o(busy), .done_o(done),
        .errors_o(errors), .completed_o(completed), .first_err_o(first_err),
        .overrun_o(overrun), .timeout_o(timeout)
    );

    // Responder: the k-th issued op gets the table's expected answer, optionally corrupted.
    logic [15:0] m_res;
    logic [3:0]  m_flg;
    logic [2:0]  pv;
    logic [15:0] pr [3];
    logic [3:0]  pf [3];
    assign m_res         = vr[op_k[1:0]] ^ {15'd0, bad_res && op_k == 2};
    assign m_flg         = vf[op_k[1:0]] ^ {3'd0, bad_flg && op_k == 3};
    assign ifc.res_valid = inj || (!mute && (slow ? pv[2] : ifc.op_valid));
    assign ifc.result    = slow ? pr[2] : m_res;
    assign ifc.flags     = slow ? pf[2] : m_flg;

    always_ff @(posedge clk) op_k <= start ? 0 : op_k + int'(ifc.op_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pv <= '0;
        else begin
            pv <= {pv[1:0], ifc.op_valid};
            pr <= '{m_res, pr[0], pr[1]};
            pf <= '{m_flg, pf[0], pf[1]};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n, output int cyc);
        int ops, res;
        @(negedge clk); start = 1'b1; count = (AW+1)'(n);
        @(negedge clk); start = 1'b0;
        check("start_drops_done", done, 0);
        ops = 0; res = 0; max_out = 0; cyc = 0;
        while (!done && cyc < 200) begin
            cyc++;
            if (ifc.op_valid) begin
                if (ops == 1) op1 = {ifc.x, ifc.y, ifc.z, ifc.roundmode, ifc.mul, ifc.add, ifc.negp, ifc.negz};
                ops++;
            end
            if (ifc.res_valid) res++;
            if (ops - res > max_out) max_out = ops - res;
            @(negedge clk);
        end
        ops_seen = ops;
        check("run_finishes", cyc < 200, 1);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, errors, completed, first_err, overrun, timeout, ifc.op_valid}, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = {vx[i], vy[i], vz[i], vc[i], vr[i], vf[i]};
        end
        @(negedge clk); wr_en = 1'b0;

        run(4, c0);
        check("lat0_done", done, 1);
        check("lat0_completed", completed, 4);
        check("lat0_errors", errors, 0);
        check("lat0_overrun", overrun, 0);
        check("lat0_outstanding", max_out, 0);
        check("lat0_op1_fields", op1, {16'h4000, 16'h4200, 16'h3C00, 2'b11, 4'b1101});
        repeat (5) @(negedge clk);
        check("done_held", {done, busy}, 2'b10);

        slow = 1'b1;
        run(4, c1);
        check("lat3_completed", completed, 4);
        check("lat3_errors", errors, 0);
        check("lat3_overrun", overrun, 0);
        check("lat3_max_outstanding", max_out, 2);
        check("lat3_ops_issued", ops_seen, 4);
        check("lat3_throttled", c1 > c0, 1);

        slow = 1'b0; bad_res = 1'b1; bad_flg = 1'b1;
        run(4, c0);
`ifdef FMA_CHK_FLAGS_EN
        check("corrupt_errors", errors, 2);
`else
        check("corrupt_errors", errors, 1);
`endif
        check("corrupt_first_err", first_err, 2);
        check("corrupt_completed", completed, 4);

        bad_res = 1'b0; bad_flg = 1'b0; mute = 1'b1;
        run(4, c2);
        check("wd_timeout", timeout, 1);
        check("wd_done_not_busy", {done, busy}, 2'b10);
        check("wd_latency", (c2 >= 16) && (c2 <= 21), 1);
        check("wd_completed", completed, 0);

        mute = 1'b0; slow = 1'b1;
        @(negedge clk); start = 1'b1; count = 5'd4;
        @(negedge clk); start = 1'b0;
        c0 = 0; c1 = 0;
        while (c0 < 4 && c1 < 50) begin
            c0 += int'(ifc.op_valid);
            c1++;
            @(negedge clk);
        end
        check("drain_busy", {busy, done}, 2'b10);
        reset = 1'b0;
        #1;
        check("reset_drain_outputs", {busy, done, errors, completed, first_err, overrun, timeout, ifc.op_valid, ifc.x}, 0);
        @(negedge clk); reset = 1'b1; slow = 1'b0;

        @(negedge clk); inj = 1'b1;
        @(negedge clk); inj = 1'b0;
        check("idle_overrun", overrun, 1);
        check("idle_overrun_errors", errors, 1);
        check("idle_overrun_completed", completed, 0);

        run(4, c0);
        check("rerun_errors", errors, 0);
        check("rerun_completed", completed, 4);
        check("rerun_flags", {overrun, timeout}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
